// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - E-stage multiply/divide unit owning HI/LO (option macro: MULT_MULTICYCLE_EN)
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // ALU decoder encodings for the HI/LO instruction group
  localparam logic [4:0] MULT_CONTROL  = 5'b01011;
  localparam logic [4:0] MULTU_CONTROL = 5'b01100;
  localparam logic [4:0] DIV_CONTROL   = 5'b01101;
  localparam logic [4:0] DIVU_CONTROL  = 5'b01110;
  localparam logic [4:0] MTHI_CONTROL  = 5'b01111;
  localparam logic [4:0] MTLO_CONTROL  = 5'b10000;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

`ifdef MULT_MULTICYCLE_EN
  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE, MUL_RUN} state_t;
`else
  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE} state_t;
`endif

  state_t state, next_state;

  logic op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
  logic fire, issue_div;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // Iterative divider: quot starts as the dividend magnitude and is
  // shifted out MSB first while quotient bits are shifted in.
  logic [WIDTH-1:0] quot, rem, den;
  logic             neg_q, neg_r;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial, q_final, r_final;
  logic             take;

  assign op_mult  = (alucontrol == MULT_CONTROL);
  assign op_multu = (alucontrol == MULTU_CONTROL);
  assign op_div   = (alucontrol == DIV_CONTROL);
  assign op_divu  = (alucontrol == DIVU_CONTROL);
  assign op_mthi  = (alucontrol == MTHI_CONTROL);
  assign op_mtlo  = (alucontrol == MTLO_CONTROL);

  // Only IDLE accepts a new op, so the held instruction in DIV_DONE never re-issues
  assign fire      = en & ~flush;
  assign issue_div = (state == IDLE) & fire & (op_div | op_divu);

  assign product = op_mult ? ({{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b})
                           : ({{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b});

  // Signed divide works on magnitudes; -MIN wraps to MIN which is its correct unsigned magnitude
  assign a_mag = (op_div & a[WIDTH-1]) ? -a : a;
  assign b_mag = (op_div & b[WIDTH-1]) ? -b : b;

  // A zero divisor always "fits", which naturally yields all-ones quotient and |a| remainder
  assign shifted = {rem, quot[WIDTH-1]};
  assign take    = (shifted >= {1'b0, den});
  assign trial   = shifted[WIDTH-1:0] - den;
  assign q_final = neg_q ? -quot : quot;
  assign r_final = neg_r ? -rem : rem;

`ifdef MULT_MULTICYCLE_EN
  logic               issue_mul;
  logic [2*WIDTH-1:0] staged;

  assign issue_mul = (state == IDLE) & fire & (op_mult | op_multu);

  // Product staging register for the two-cycle multiply
  always_ff @(posedge clk or posedge rst) begin
    if (rst) staged <= '0;
    else if (issue_mul) staged <= product;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; flush abandons any operation in flight
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (issue_div) next_state = DIV_RUN;
`ifdef MULT_MULTICYCLE_EN
          else if (issue_mul) next_state = MUL_RUN;
`endif
        end
        DIV_RUN:  if (count == LAST_ITER) next_state = DIV_DONE;
        DIV_DONE: next_state = IDLE;
`ifdef MULT_MULTICYCLE_EN
        MUL_RUN:  next_state = IDLE;
`endif
        default:  next_state = IDLE;
      endcase
    end
  end

  // Stall output: issue cycle plus every DIV_RUN cycle, released by flush or reset
  always_comb begin
    stall_o = 1'b0;
    if (!rst && !flush) begin
      case (state)
`ifdef MULT_MULTICYCLE_EN
        IDLE:    stall_o = issue_div | issue_mul;
`else
        IDLE:    stall_o = issue_div;
`endif
        DIV_RUN: stall_o = 1'b1;
        default: stall_o = 1'b0;
      endcase
    end
  end

  // Divider datapath: latch operands at issue, one restoring step per DIV_RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot  <= '0;
      rem   <= '0;
      den   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      count <= '0;
    end else if (issue_div) begin
      quot  <= a_mag;
      rem   <= '0;
      den   <= b_mag;
      neg_q <= op_div & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= op_div & a[WIDTH-1];
      count <= '0;
    end else if (state == DIV_RUN) begin
      rem   <= take ? trial : shifted[WIDTH-1:0];
      quot  <= {quot[WIDTH-2:0], take};
      count <= count + CW'(1);
    end
  end

  // Architectural HI/LO update; nothing commits in a flushed cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (!flush) begin
      if (state == IDLE && fire) begin
        if (op_mthi) hi_o <= a;
        if (op_mtlo) lo_o <= a;
`ifndef MULT_MULTICYCLE_EN
        if (op_mult | op_multu) {hi_o, lo_o} <= product;
`endif
      end else if (state == DIV_DONE) begin
        hi_o <= r_final;
        lo_o <= q_final;
      end
`ifdef MULT_MULTICYCLE_EN
      else if (state == MUL_RUN) begin
        {hi_o, lo_o} <= staged;
      end
`endif
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - randomized bench for hilo_muldiv against an arithmetic HI/LO model
`timescale 1ns/1ps
module tb_hilo_muldiv;

  localparam logic [4:0] MULT_C  = 5'b01011;
  localparam logic [4:0] MULTU_C = 5'b01100;
  localparam logic [4:0] DIV_C   = 5'b01101;
  localparam logic [4:0] DIVU_C  = 5'b01110;
  localparam logic [4:0] MTHI_C  = 5'b01111;
  localparam logic [4:0] MTLO_C  = 5'b10000;
  localparam logic [4:0] ADD_C   = 5'b00010;

  logic        clk = 1'b0;
  logic        rst, en, flush, stall_o;
  logic [4:0]  alucontrol;
  logic [31:0] a, b, hi_o, lo_o;

  int   checks = 0;
  int   errors = 0;
  int   stall_cnt = 0;
  bit   chk_on = 1'b0;
  logic exp_stall;
  logic [31:0] m_hi, m_lo;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .en(en), .alucontrol(alucontrol),
    .a(a), .b(b), .flush(flush),
    .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (stall_o === 1'b1) stall_cnt++;
    if (chk_on) begin
      check("stall", {31'b0, stall_o}, {31'b0, exp_stall});
      check("hi", hi_o, m_hi);
      check("lo", lo_o, m_lo);
    end
  end

  function automatic logic [63:0] mul_ref(input bit sgn, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    longint unsigned ux, uy;
    if (sgn) begin
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
    end
    ux = x;
    uy = y;
    return ux * uy;
  endfunction

  function automatic void div_ref(input bit sgn, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sx, sy;
    if (y == 0) begin
      q = (sgn && x[31]) ? 32'd1 : 32'hFFFFFFFF;
      r = x;
    end else if (sgn) begin
      sx = $signed(x);
      sy = $signed(y);
      q = 32'(sx / sy);
      r = 32'(sx % sy);
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0;
    flush = 1'b0;
    exp_stall = 1'b0;
    alucontrol = 5'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic do_reset();
    #2;
    chk_on = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    check("rst_stall", {31'b0, stall_o}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_hi = 32'h0;
    m_lo = 32'h0;
    idle();
    chk_on = 1'b1;
  endtask

  // abort: 0 none, 1 flush in cycle T+k, 2 reset in cycle T+k
  task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit fl, input int abort, input int k);
    logic [63:0] p;
    logic [31:0] q, r;
    bit is_div, is_mul;
    is_div = (op == DIV_C) || (op == DIVU_C);
    is_mul = (op == MULT_C) || (op == MULTU_C);
    en = 1'b1; alucontrol = op; a = x; b = y; flush = fl;
    exp_stall = !fl && is_div;
`ifdef MULT_MULTICYCLE_EN
    if (!fl && is_mul) exp_stall = 1'b1;
`endif
    if (fl) begin
      step();
      idle();
      return;
    end
    if (op == MTHI_C) begin
      step();
      m_hi = x;
    end else if (op == MTLO_C) begin
      step();
      m_lo = x;
    end else if (is_mul) begin
      p = mul_ref(op == MULT_C, x, y);
`ifdef MULT_MULTICYCLE_EN
      step();
      exp_stall = 1'b0;
      if (abort == 1) begin
        flush = 1'b1;
        step();
        idle();
        return;
      end
`endif
      step();
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (is_div) begin
      div_ref(op == DIV_C, x, y, q, r);
      step();
      for (int i = 1; i <= 33; i++) begin
        if (i == 33) begin
          alucontrol = op; a = x; b = y; exp_stall = 1'b0;
        end else begin
          alucontrol = 5'($urandom); a = $urandom; b = $urandom;
        end
        if (abort != 0 && i == k) begin
          if (abort == 1) begin
            flush = 1'b1;
            exp_stall = 1'b0;
            step();
            idle();
          end else begin
            do_reset();
          end
          return;
        end
        step();
      end
      m_hi = r;
      m_lo = q;
    end else begin
      step();
    end
    idle();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int base;
    logic [4:0] ops [8];
    logic [31:0] x, y;
    ops = '{MULT_C, MULTU_C, DIV_C, DIVU_C, MTHI_C, MTLO_C, ADD_C, 5'b00000};
    rst = 1'b1; en = 1'b0; flush = 1'b0; alucontrol = 5'b0; a = 32'h0; b = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0; exp_stall = 1'b0;
    #12;
    check("reset_hi", hi_o, 32'h0);
    check("reset_lo", lo_o, 32'h0);
    check("reset_stall", {31'b0, stall_o}, 32'h0);
    step();
    rst = 1'b0;
    chk_on = 1'b1;

    issue(MULT_C, 32'hFFFFFFFE, 32'd3, 0, 0, 0);
    check("mult_hi", hi_o, 32'hFFFFFFFF);
    check("mult_lo", lo_o, 32'hFFFFFFFA);
    issue(MULTU_C, 32'hFFFFFFFE, 32'd3, 0, 0, 0);
    check("multu_hi", hi_o, 32'h00000002);
    check("multu_lo", lo_o, 32'hFFFFFFFA);

    base = stall_cnt;
    issue(DIV_C, 32'hFFFFFFF9, 32'd2, 0, 0, 0);
    check("div_stall_cycles", 32'(stall_cnt - base), 32'd33);
    check("div_lo", lo_o, 32'hFFFFFFFD);
    check("div_hi", hi_o, 32'hFFFFFFFF);
    issue(DIVU_C, 32'd100, 32'd0, 0, 0, 0);
    check("divu0_lo", lo_o, 32'hFFFFFFFF);
    check("divu0_hi", hi_o, 32'd100);
    issue(DIV_C, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);
    check("divmin_lo", lo_o, 32'h80000000);
    check("divmin_hi", hi_o, 32'h0);

    issue(DIV_C, 32'd77, 32'd5, 0, 1, 10);
    check("flush_hi", hi_o, 32'h0);
    check("flush_lo", lo_o, 32'h80000000);
    issue(MTLO_C, 32'h1234, 32'h0, 0, 0, 0);
    check("mtlo_lo", lo_o, 32'h1234);
    issue(MTHI_C, 32'hA5A5A5A5, 32'h0, 0, 0, 0);
    check("mthi_hi", hi_o, 32'hA5A5A5A5);
    issue(MTHI_C, 32'hDEADBEEF, 32'h0, 1, 0, 0);
    check("flush_fire_hi", hi_o, 32'hA5A5A5A5);

    issue(DIV_C, 32'd123, 32'd7, 0, 2, 5);
    check("rstdiv_hi", hi_o, 32'h0);

`ifdef MULT_MULTICYCLE_EN
    base = stall_cnt;
    issue(MULT_C, 32'd6, 32'd7, 0, 0, 0);
    check("mul_stall_cycles", 32'(stall_cnt - base), 32'd1);
    check("mul_mc_lo", lo_o, 32'd42);
`endif

    for (int n = 0; n < 60; n++) begin
      logic [4:0] op;
      int ab;
      op = ops[$urandom_range(0, 7)];
      x = pick();
      y = pick();
      ab = ($urandom_range(0, 7) == 0) ? 1 : 0;
      if (($urandom_range(0, 9) == 0)) issue(op, x, y, 1, 0, 0);
      else issue(op, x, y, 0, ab, $urandom_range(1, 33));
      if ($urandom_range(0, 3) == 0) step();
    end

    step();
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
